// File: rtl/ternary_neuron_acc.sv
// Ternary neuron accumulator: sums per-beat (positive - negative) popcounts over a frame
// and emits one thresholded activation (+1 / 0 / -1) with the saturated sum.
module ternary_neuron_acc #(
    parameter int ACC_W     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       pc_pos,
    input  logic [3:0]       pc_neg,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [ACC_W-1:0] thr_pos,
    input  logic [ACC_W-1:0] thr_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_trit,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_err
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] thr_pos_q;
    logic signed [ACC_W-1:0] thr_neg_q;
    logic [CNT_W-1:0]        beat_cnt;

    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] thr_pos_use;
    logic signed [ACC_W-1:0] thr_neg_use;
    logic [1:0]              trit_next;
    logic                    beat_acc;
    logic                    last_cnt;
    logic                    frame_end;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid holds its payload stable until that edge, ready never depends on valid.
    always_comb begin
        beat_acc  = in_valid & in_ready;
        last_cnt  = (beat_cnt == CNT_W'(MAX_BEATS - 1));
        frame_end = in_last | last_cnt;

        sum_wide = {acc[ACC_W-1], acc}
                 + {{(ACC_W-3){1'b0}}, pc_pos}
                 - {{(ACC_W-3){1'b0}}, pc_neg};

        if (sum_wide > SUM_MAX) begin
            acc_next = SUM_MAX[ACC_W-1:0];
        end else if (sum_wide < SUM_MIN) begin
            acc_next = SUM_MIN[ACC_W-1:0];
        end else begin
            acc_next = sum_wide[ACC_W-1:0];
        end

        // The first beat of a frame is classified against the thresholds it samples.
        thr_pos_use = (beat_cnt == '0) ? thr_pos : thr_pos_q;
        thr_neg_use = (beat_cnt == '0) ? thr_neg : thr_neg_q;

        if (acc_next > thr_pos_use) begin
            trit_next = 2'b01;
        end else if (acc_next < thr_neg_use) begin
            trit_next = 2'b11;
        end else begin
            trit_next = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            beat_cnt  <= '0;
            thr_pos_q <= '0;
            thr_neg_q <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_trit  <= 2'b00;
            out_sum   <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (beat_acc) begin
                        if (beat_cnt == '0) begin
                            thr_pos_q <= thr_pos;
                            thr_neg_q <= thr_neg;
                        end
                        acc      <= acc_next;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (frame_end) begin
                            out_sum   <= acc_next;
                            out_trit  <= trit_next;
                            out_err   <= last_cnt & ~in_last;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    // Result fields stay as last written; only valid drops.
                    if (out_ready) begin
                        acc       <= '0;
                        beat_cnt  <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_ACC;
                    end
                end
                default: begin
                    state <= ST_ACC;
                end
            endcase
        end
    end

endmodule
